allophone_queue: RTL and testbench
==================================

Name: allophone_queue

Overview:
- Host-side allophone buffer sitting directly upstream of the Speech256 controller.
- Accepts 6-bit allophone codes from the host at any rate and stores them in a small circular FIFO.
- Presents codes one at a time to the controller, using the controller's ldq / data_stb handshake.
- Reports full/empty/level/overflow/busy status so host firmware can stream phrases without polling the controller.

Parameters:
- DEPTH_LOG2, 3, log2 of FIFO depth (default depth 8 entries).
- ALLO_W, 6, allophone code width; fixed at 6 to match the controller data_in.

Ports:
- clk  in  1  global Speech256 clock
- rst_an  in  1  asynchronous reset, active low
- host_data  in  6  allophone code from host
- host_wr  in  1  one-cycle write strobe for host_data
- flush  in  1  synchronous clear of FIFO contents and overflow flag
- ldq  in  1  controller load request; high when a new allophone can be loaded
- data_out  out  6  allophone code to controller data_in
- data_stb  out  1  one-cycle strobe to controller data_stb
- full  out  1  FIFO holds 2^DEPTH_LOG2 entries
- empty  out  1  FIFO holds 0 entries
- level  out  DEPTH_LOG2+1  number of stored entries
- overflow  out  1  sticky: a write was dropped because FIFO was full
- busy  out  1  queue non-empty, handshake in progress, or controller not requesting

Behaviour:
Reset (rst_an low, asynchronous):
- data_out=0, data_stb=0, level=0, empty=1, full=0, overflow=0.
- Pointers are zeroed and the FSM enters S_WAIT.
- Reset mid-handshake abandons the code in flight; no strobe is issued after reset release until the conditions below hold.

Storage:
- Circular buffer with rd_ptr/wr_ptr of DEPTH_LOG2 bits, wrapping modulo depth.
- Separate count register of DEPTH_LOG2+1 bits drives level.
- full = (count == 2^DEPTH_LOG2); empty = (count == 0). Both are combinational from count.

Write:
- host_wr=1 and full=0: store at wr_ptr, then wr_ptr+1 and count+1 at the clock edge.
- host_wr=1 and full=1: write dropped and overflow<=1. Full is judged on the pre-edge count, so a simultaneous pop does not rescue the write.

FSM (all outputs registered):
- S_WAIT: data_stb<=0.
  - If ldq=1, empty=0 and flush=0: data_out<=mem[rd_ptr], data_stb<=1, rd_ptr+1, count-1, go to S_HOLD.
- S_HOLD: data_stb<=0.
  - Stay until ldq=0 is sampled, then go to S_WAIT.
  - This guarantees exactly one strobe per controller request. The controller drops ldq one cycle after seeing data_stb, so S_HOLD always lasts at least 2 cycles.

Handshake timing:
- Latency from ldq rising (queue non-empty) to data_stb high is 1 cycle.
- data_stb is high for exactly 1 cycle.
- data_out stays stable from the strobe cycle until the next strobe.

Simultaneous events:
- Write and pop in the same cycle with 0 < count < depth: count unchanged, both pointers advance.
- Write and pop in the same cycle with count=0: no pop (empty); the write lands and count becomes 1.

Flush:
- Zeroes pointers, count and overflow.
- Has priority over a same-cycle host_wr (the write is dropped and overflow is not set) and blocks a pop in S_WAIT.
- In S_HOLD, flush does not alter the FSM; the code already strobed remains valid at the controller.

Status:
- busy = !empty | (state==S_HOLD) | data_stb | !ldq, combinational.
- After reset busy may read 1 until the controller first raises ldq.

Decomposition:
- Shared package speech256_pkg holds:
  - ALLO_W=6;
  - FSM encodings S_WAIT=1'b0, S_HOLD=1'b1;
  - pause allophone codes PA1..PA5 (0..4) for bench and firmware use.
- One natural sub-module, allo_fifo_mem: a DEPTH x ALLO_W register array with a synchronous write port and an asynchronous read port.
- The FSM, pointers and status logic stay in allophone_queue.

Test Plan:
1. Reset, ldq held 1, write 0x2A → data_stb pulses for 1 cycle, 1 cycle after the write edge; data_out=0x2A; level returns to 0; no second strobe while ldq stays 1.
2. ldq=0, write 0x01,0x02,0x03; then emulate the controller (drop ldq 1 cycle after each strobe, raise it again 20 cycles later) → strobes in order 0x01,0x02,0x03 spaced ≥22 cycles; level goes 3→2→1→0.
3. ldq=0, write 9 codes with depth 8 → full=1 after the 8th write; the 9th is dropped; overflow=1; level=8; draining yields codes 1..8 only.
4. level=8 (full), host_wr and pop in the same cycle → write dropped, overflow=1, level=7; level=0 with a write while ldq=1 → level becomes 1, then strobe on the next cycle.
5. level=5, overflow=1, flush with host_wr simultaneously → level=0, empty=1, overflow=0, no strobe even though ldq=1.
6. Assert rst_an low during S_HOLD with level=4 → outputs return to reset values immediately (asynchronously); after release with ldq=1 and a new write 0x15 → single strobe with data_out=0x15.

Source files
------------

// File: rtl/speech256_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : speech256_pkg                                           |
// | Purpose  : Shared Speech256 constants, queue FSM encoding, pauses  |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
package speech256_pkg;

  localparam int ALLO_W = 6;

  typedef enum logic [0:0] {
    S_WAIT = 1'b0,
    S_HOLD = 1'b1
  } q_state_t;

  // Pause allophones, handy for firmware phrase tables.
  localparam logic [ALLO_W-1:0] PA1 = 6'd0;
  localparam logic [ALLO_W-1:0] PA2 = 6'd1;
  localparam logic [ALLO_W-1:0] PA3 = 6'd2;
  localparam logic [ALLO_W-1:0] PA4 = 6'd3;
  localparam logic [ALLO_W-1:0] PA5 = 6'd4;

endpackage
`default_nettype wire

// File: rtl/allo_fifo_mem.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : allo_fifo_mem                                           |
// | Purpose  : Allophone register array, sync write / async read       |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module allo_fifo_mem #(
  parameter int DEPTH_LOG2 = 3,
  parameter int ALLO_W     = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [ALLO_W-1:0]     wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [ALLO_W-1:0]     rdata
);
  import speech256_pkg::*;

  localparam int c_depth = 1 << DEPTH_LOG2;

  logic [ALLO_W-1:0] r_mem [c_depth];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/allophone_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : allophone_queue                                         |
// | Purpose  : Host allophone FIFO feeding the Speech256 ldq handshake |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module allophone_queue #(
  parameter int DEPTH_LOG2 = 3,
  parameter int ALLO_W     = 6
) (
  input  logic                  clk,
  input  logic                  rst_an,
  input  logic [ALLO_W-1:0]     host_data,
  input  logic                  host_wr,
  input  logic                  flush,
  input  logic                  ldq,
  output logic [ALLO_W-1:0]     data_out,
  output logic                  data_stb,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  busy
);
  import speech256_pkg::*;

  localparam logic [DEPTH_LOG2:0]   c_depth   = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   c_cnt_one = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] c_ptr_one = DEPTH_LOG2'(1);

  q_state_t                r_state, w_state_nxt;
  logic [DEPTH_LOG2-1:0]   r_rd_ptr, r_wr_ptr;
  logic [DEPTH_LOG2:0]     r_count, w_count_nxt;
  logic [ALLO_W-1:0]       r_data_out, w_data_out_nxt, w_rd_data;
  logic                    r_data_stb, w_data_stb_nxt;
  logic                    r_overflow;
  logic                    w_full, w_empty, w_push, w_pop;

  assign w_full  = (r_count == c_depth);
  assign w_empty = (r_count == '0);
  // Fullness is judged before the edge, so a same-cycle pop never rescues a write.
  assign w_push  = host_wr & ~w_full & ~flush;

  allo_fifo_mem #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .ALLO_W     (ALLO_W)
  ) u_mem (
    .clk   (clk),
    .we    (w_push),
    .waddr (r_wr_ptr),
    .wdata (host_data),
    .raddr (r_rd_ptr),
    .rdata (w_rd_data)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_pop          = 1'b0;
    w_data_stb_nxt = 1'b0;
    w_data_out_nxt = r_data_out;
    case (r_state)
      S_WAIT: begin
        if (ldq && !w_empty && !flush) begin
          w_pop          = 1'b1;
          w_data_stb_nxt = 1'b1;
          w_data_out_nxt = w_rd_data;
          w_state_nxt    = S_HOLD;
        end
      end
      S_HOLD: begin
        // One strobe per request: re-arm only once the controller drops ldq.
        if (!ldq) begin
          w_state_nxt = S_WAIT;
        end
      end
      default: w_state_nxt = S_WAIT;
    endcase
  end

  always_comb begin
    w_count_nxt = r_count;
    if (flush) begin
      w_count_nxt = '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + c_cnt_one;
        2'b01:   w_count_nxt = r_count - c_cnt_one;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      r_state    <= S_WAIT;
      r_data_stb <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_data_stb <= w_data_stb_nxt;
      r_data_out <= w_data_out_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      if (flush) begin
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + c_ptr_one;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + c_ptr_one;
        end
        if (host_wr && w_full) begin
          r_overflow <= 1'b1;
        end
      end
    end
  end

  assign data_out = r_data_out;
  assign data_stb = r_data_stb;
  assign full     = w_full;
  assign empty    = w_empty;
  assign level    = r_count;
  assign overflow = r_overflow;
  assign busy     = ~w_empty | (r_state == S_HOLD) | r_data_stb | ~ldq;

endmodule
`default_nettype wire

// File: tb/tb_allophone_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_allophone_queue                                      |
// | Purpose  : Directed + random bench with queue-based reference model|
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_allophone_queue;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_an, host_wr, flush, ldq;
  logic [5:0] host_data;
  logic [5:0] data_out;
  logic       data_stb, full, empty, overflow, busy;
  logic [3:0] level;

  allophone_queue #(.DEPTH_LOG2(3), .ALLO_W(6)) dut (
    .clk       (clk),
    .rst_an    (rst_an),
    .host_data (host_data),
    .host_wr   (host_wr),
    .flush     (flush),
    .ldq       (ldq),
    .data_out  (data_out),
    .data_stb  (data_stb),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the queue contents plus "request already served" flag.
  logic [5:0] mq[$];
  logic [5:0] m_dout   = '0;
  bit         m_stb    = 1'b0;
  bit         m_ovf    = 1'b0;
  bit         m_served = 1'b0;
  bit         m_pop;
  int         m_n;

  always @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      mq.delete();
      m_dout = '0; m_stb = 1'b0; m_ovf = 1'b0; m_served = 1'b0;
    end else begin
      m_n   = mq.size();
      m_pop = !m_served && ldq && (m_n > 0) && !flush;
      m_stb = 1'b0;
      if (flush) begin
        mq.delete();
        m_ovf = 1'b0;
      end else begin
        if (m_pop) begin
          m_dout   = mq.pop_front();
          m_stb    = 1'b1;
          m_served = 1'b1;
        end
        if (host_wr) begin
          if (m_n == DEPTH) m_ovf = 1'b1;
          else mq.push_back(host_data);
        end
      end
      if (!m_pop && m_served && !ldq) m_served = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_an !== 1'bx) begin
      chk("data_out", int'(data_out), int'(m_dout));
      chk("data_stb", int'(data_stb), int'(m_stb));
      chk("level",    int'(level),    mq.size());
      chk("full",     int'(full),     int'(mq.size() == DEPTH));
      chk("empty",    int'(empty),    int'(mq.size() == 0));
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("busy",     int'(busy),     int'((mq.size() != 0) || m_served || m_stb || !ldq));
    end
  end

  // Controller emulation and strobe logging.
  bit         ctrl_en = 1'b0;
  bit         stb_d   = 1'b0;
  int         ctrl_cnt = 0;
  int         ctrl_gap = 20;
  bit         ctrl_rand = 1'b0;
  int         cyc = 0;
  logic [5:0] stb_log[$];
  int         lev_log[$];
  int         time_log[$];

  task automatic tick();
    @(posedge clk);
    #2;
    if (ctrl_en) begin
      if (ctrl_cnt > 0) begin
        ctrl_cnt--;
        if (ctrl_cnt == 0) ldq = 1'b1;
      end else if (stb_d) begin
        ldq      = 1'b0;
        ctrl_cnt = ctrl_rand ? int'($urandom_range(1, 6)) : ctrl_gap;
      end
      stb_d = data_stb;
    end
    if (data_stb) begin
      stb_log.push_back(data_out);
      lev_log.push_back(int'(level));
      time_log.push_back(cyc);
    end
    cyc++;
  endtask

  task automatic wr(input logic [5:0] d);
    host_data = d;
    host_wr   = 1'b1;
    tick();
    host_wr   = 1'b0;
  endtask

  task automatic settle();
    ctrl_en = 1'b0; ctrl_cnt = 0; stb_d = 1'b0; ldq = 1'b0;
    tick();
    tick();
  endtask

  task automatic drain_to(input int target, input int gap);
    ctrl_gap = gap; ctrl_cnt = 0; stb_d = 1'b0; ctrl_en = 1'b1; ldq = 1'b1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (int'(level) == target) break;
    end
    chk("drain_level", int'(level), target);
    settle();
  endtask

  initial begin
    rst_an = 1'b1; host_wr = 1'b0; host_data = '0; flush = 1'b0; ldq = 1'b0;
    #1 rst_an = 1'b0;
    #1;
    chk("rst_level", int'(level), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_stb", int'(data_stb), 0);
    tick(); tick();
    rst_an = 1'b1;
    tick();

    // 1: single code with ldq held high
    ldq = 1'b1;
    tick(); tick();
    stb_log.delete();
    wr(6'h2A);
    chk("t1_level1", int'(level), 1);
    chk("t1_stb_early", int'(data_stb), 0);
    tick();
    chk("t1_stb", int'(data_stb), 1);
    chk("t1_dout", int'(data_out), 'h2A);
    chk("t1_level0", int'(level), 0);
    tick();
    chk("t1_stb_once", int'(data_stb), 0);
    repeat (6) tick();
    chk("t1_strobes", stb_log.size(), 1);
    chk("t1_dout_hold", int'(data_out), 'h2A);
    settle();

    // 2: three codes with controller pacing
    wr(6'h01); wr(6'h02); wr(6'h03);
    chk("t2_level3", int'(level), 3);
    stb_log.delete(); lev_log.delete(); time_log.delete();
    drain_to(0, 20);
    repeat (4) tick();
    chk("t2_strobes", stb_log.size(), 3);
    if (stb_log.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("t2_code", int'(stb_log[i]), i + 1);
        chk("t2_level", lev_log[i], 2 - i);
      end
      chk("t2_gap1_ok", int'(time_log[1] - time_log[0] >= 22), 1);
      chk("t2_gap2_ok", int'(time_log[2] - time_log[1] >= 22), 1);
    end

    // 3: overfill by one
    stb_log.delete();
    for (int i = 1; i <= 9; i++) begin
      wr(6'(i));
      if (i == 8) chk("t3_full8", int'(full), 1);
      if (i == 8) chk("t3_ovf_clear8", int'(overflow), 0);
    end
    chk("t3_level", int'(level), 8);
    chk("t3_ovf", int'(overflow), 1);
    drain_to(0, 3);
    repeat (5) tick();
    chk("t3_strobes", stb_log.size(), 8);
    if (stb_log.size() == 8)
      for (int i = 0; i < 8; i++) chk("t3_code", int'(stb_log[i]), i + 1);

    // 4: write and pop while full, then write into empty queue with ldq high
    flush = 1'b1; tick(); flush = 1'b0;
    chk("t4_ovf_flushed", int'(overflow), 0);
    for (int i = 0; i < 8; i++) wr(6'h10 + 6'(i));
    ldq = 1'b1; host_data = 6'h3F; host_wr = 1'b1;
    tick();
    host_wr = 1'b0;
    chk("t4_stb", int'(data_stb), 1);
    chk("t4_dout", int'(data_out), 'h10);
    chk("t4_level7", int'(level), 7);
    chk("t4_ovf", int'(overflow), 1);
    settle();
    drain_to(0, 2);
    ldq = 1'b1;
    tick();
    wr(6'h2B);
    chk("t4_level1", int'(level), 1);
    chk("t4_no_stb_yet", int'(data_stb), 0);
    tick();
    chk("t4_stb2", int'(data_stb), 1);
    chk("t4_dout2", int'(data_out), 'h2B);
    chk("t4_level0", int'(level), 0);
    settle();

    // 5: flush beats a same-cycle write and a pending pop
    for (int i = 0; i < 9; i++) wr(6'h30 + 6'(i));
    drain_to(5, 2);
    chk("t5_level5", int'(level), 5);
    chk("t5_ovf", int'(overflow), 1);
    ldq = 1'b1; flush = 1'b1; host_wr = 1'b1; host_data = 6'h11;
    tick();
    flush = 1'b0; host_wr = 1'b0;
    chk("t5_level0", int'(level), 0);
    chk("t5_empty", int'(empty), 1);
    chk("t5_ovf0", int'(overflow), 0);
    chk("t5_no_stb", int'(data_stb), 0);
    tick();
    chk("t5_no_stb2", int'(data_stb), 0);
    settle();

    // 6: asynchronous reset mid-handshake
    for (int i = 0; i < 5; i++) wr(6'h20 + 6'(i));
    ldq = 1'b1;
    tick();
    chk("t6_stb", int'(data_stb), 1);
    chk("t6_level4", int'(level), 4);
    #1 rst_an = 1'b0;
    #1;
    chk("t6_rst_stb", int'(data_stb), 0);
    chk("t6_rst_level", int'(level), 0);
    chk("t6_rst_empty", int'(empty), 1);
    chk("t6_rst_dout", int'(data_out), 0);
    tick();
    rst_an = 1'b1;
    tick();
    stb_log.delete();
    wr(6'h15);
    repeat (8) tick();
    chk("t6_strobes", stb_log.size(), 1);
    if (stb_log.size() > 0) chk("t6_dout", int'(stb_log[0]), 'h15);
    settle();

    // Random traffic against the model
    ctrl_rand = 1'b1; ctrl_cnt = 0; stb_d = 1'b0; ctrl_en = 1'b1; ldq = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      host_wr   = ($urandom_range(0, 99) < 45);
      host_data = 6'($urandom);
      flush     = ($urandom_range(0, 99) < 2);
      tick();
    end
    host_wr = 1'b0; flush = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
